// File: rtl/arp_pkg.sv
// Shared ARP constants, slot/state types and the reply word formatter.
// Reused by the receive parser and the transmit scheduler.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OP_REQ     = 16'd1;
  localparam logic [15:0] ARP_OP_REP     = 16'd2;
  localparam int          ARP_WORDS      = 7;

  typedef enum logic {IDLE, SEND} arp_state_e;

  typedef struct packed {
    logic        vld;
    logic [47:0] mac;
    logic [31:0] ip;
  } arp_slot_t;

  // Word idx of the 7-word reply; rmac/rip are the requester's addresses.
  function automatic logic [31:0] arp_reply_word(input logic [2:0]  idx,
                                                 input logic [47:0] lmac,
                                                 input logic [31:0] lip,
                                                 input logic [47:0] rmac,
                                                 input logic [31:0] rip);
    case (idx)
      3'd0:    return {ARP_HTYPE_ETH, ARP_PTYPE_IPV4};
      3'd1:    return {ARP_HLEN, ARP_PLEN, ARP_OP_REP};
      3'd2:    return lmac[47:16];
      3'd3:    return {lmac[15:0], lip[31:16]};
      3'd4:    return {lip[15:0], rmac[47:32]};
      3'd5:    return rmac[31:0];
      3'd6:    return rip;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/arp_reply_ctrl_if.sv
// Parsed-ARP receive strobe/fields plus the 32-bit valid/ready reply stream.
// master drives requests and ready; slave is the reply scheduler.
interface arp_reply_ctrl_if;
  logic        rx_valid;
  logic [15:0] hdr_type;
  logic [15:0] proto_type;
  logic [7:0]  hdr_addr_length;
  logic [7:0]  pro_addr_length;
  logic [15:0] operation;
  logic [47:0] send_hdr_addr;
  logic [31:0] send_ip_addr;
  logic [47:0] target_hdr_addr;
  logic [31:0] target_ip_addr;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;

  modport master (
    output rx_valid, hdr_type, proto_type, hdr_addr_length, pro_addr_length,
           operation, send_hdr_addr, send_ip_addr, target_hdr_addr,
           target_ip_addr, tx_ready,
    input  tx_data, tx_valid, tx_last
  );

  modport slave (
    input  rx_valid, hdr_type, proto_type, hdr_addr_length, pro_addr_length,
           operation, send_hdr_addr, send_ip_addr, target_hdr_addr,
           target_ip_addr, tx_ready,
    output tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/arp_req_match.sv
// Combinational filter: high when the parsed fields form an Ethernet/IPv4
// ARP request whose target IP is this node.
module arp_req_match
  import arp_pkg::*;
(
  input  logic [15:0] hdr_type,
  input  logic [15:0] proto_type,
  input  logic [7:0]  hdr_addr_length,
  input  logic [7:0]  pro_addr_length,
  input  logic [15:0] operation,
  input  logic [31:0] target_ip_addr,
  input  logic [31:0] local_ip,
  output logic        match
);
  assign match = (hdr_type        == ARP_HTYPE_ETH)  &&
                 (proto_type      == ARP_PTYPE_IPV4) &&
                 (hdr_addr_length == ARP_HLEN)       &&
                 (pro_addr_length == ARP_PLEN)       &&
                 (operation       == ARP_OP_REQ)     &&
                 (target_ip_addr  == local_ip);
endmodule

// File: rtl/arp_reply_ctrl.sv
// ARP reply scheduler: filters parsed requests, queues up to two (cur/pend)
// and streams 7-word replies. Optional counters under ARP_REPLY_STATS_EN.
module arp_reply_ctrl
  import arp_pkg::*;
#(
  parameter int STATS_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [47:0]         local_mac,
  input  logic [31:0]         local_ip,
  arp_reply_ctrl_if.slave     bus,
  output logic                busy
`ifdef ARP_REPLY_STATS_EN
  ,
  output logic [STATS_W-1:0]  rx_cnt,
  output logic [STATS_W-1:0]  reply_cnt,
  output logic [STATS_W-1:0]  drop_cnt
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(ARP_WORDS - 1);

  arp_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  arp_slot_t  cur_q, cur_d, pend_q, pend_d, new_slot;
  logic       hit, accept, hs, hs_last, drop;
  logic       unused_tha;

  // The target MAC of a request is meaningless (usually zero), so it is not checked.
  assign unused_tha = ^bus.target_hdr_addr;

  arp_req_match u_match (
    .hdr_type        (bus.hdr_type),
    .proto_type      (bus.proto_type),
    .hdr_addr_length (bus.hdr_addr_length),
    .pro_addr_length (bus.pro_addr_length),
    .operation       (bus.operation),
    .target_ip_addr  (bus.target_ip_addr),
    .local_ip        (local_ip),
    .match           (hit)
  );

  assign accept   = bus.rx_valid & hit;
  assign hs       = (state_q == SEND) & bus.tx_ready;
  assign hs_last  = hs & (idx_q == LAST_IDX);
  assign new_slot = '{vld: 1'b1, mac: bus.send_hdr_addr, ip: bus.send_ip_addr};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_d   = new_slot;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && !hs_last) idx_d = idx_q + 3'd1;
        if (hs_last) begin
          idx_d = '0;
          // A request landing on the final handshake is never dropped:
          // pend frees up (or cur does, when pend is empty) on this edge.
          if (pend_q.vld) begin
            cur_d  = pend_q;
            pend_d = accept ? new_slot : '0;
          end else if (accept) begin
            cur_d = new_slot;
          end else begin
            cur_d   = '0;
            state_d = IDLE;
          end
        end else if (accept) begin
          if (!pend_q.vld) pend_d = new_slot;
          else             drop   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so W0 shows up the
  // cycle after the accepting strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cur_q        <= '0;
      pend_q       <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_last  <= 1'b0;
      bus.tx_data  <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      bus.tx_valid <= (state_d == SEND);
      bus.tx_last  <= (state_d == SEND) && (idx_d == LAST_IDX);
      bus.tx_data  <= (state_d == SEND) ?
                      arp_reply_word(idx_d, local_mac, local_ip, cur_d.mac, cur_d.ip) : '0;
      busy         <= cur_d.vld | pend_d.vld;
    end
  end

`ifdef ARP_REPLY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt    <= '0;
      reply_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (bus.rx_valid && rx_cnt != '1)  rx_cnt    <= rx_cnt + STATS_W'(1);
      if (hs_last && reply_cnt != '1)    reply_cnt <= reply_cnt + STATS_W'(1);
      if (drop && drop_cnt != '1)        drop_cnt  <= drop_cnt + STATS_W'(1);
    end
  end
`else
  localparam int unused_stats_w = STATS_W;
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
